// File: rtl/edsac_timing_pkg.sv
// edsac_timing_pkg: shared digit-timing constants, digit type and slot arbiter states.
package edsac_timing_pkg;
  localparam int WORD_DIGITS = 36;
  localparam int SHORT_DIGITS = 18;
  typedef logic [5:0] digit_t;
  typedef enum logic [1:0] {IDLE, LONG, SHORT_A, SHORT_B} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, search starting at ptr and wrapping upward.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  int best, off;
  always_comb begin
    best = N;
    off = 0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      off = (i + N - int'(ptr)) % N;
      if (req[i] && off < best) begin
        best = off;
        idx = W'(i);
      end
    end
    gnt = |req ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
  end
endmodule

// File: rtl/serial_slot_arbiter.sv
// serial_slot_arbiter: word-aligned round-robin slot scheduler locked to the digit pulse train.
// Defining EDSAC_SHORT_WORD_EN adds req_short and splits words into two 18-digit short slots.
module serial_slot_arbiter #(
  parameter int NREQ = 4,
  parameter int WORD_DIGITS = edsac_timing_pkg::WORD_DIGITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
`ifdef EDSAC_SHORT_WORD_EN
  input  logic [NREQ-1:0]          req_short,
`endif
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output edsac_timing_pkg::digit_t digit,
  output logic                     word_start,
  output logic                     word_end,
  output logic [NREQ-1:0]          xfer_done
);
  import edsac_timing_pkg::*;
  localparam int PW = $clog2(NREQ);
  localparam digit_t LAST = digit_t'(WORD_DIGITS - 1);
  localparam digit_t HALF = digit_t'(SHORT_DIGITS - 1);
  state_t state, next_state;
  logic [PW-1:0] ptr, idx;
  logic [NREQ-1:0] cand, pick;
  logic dropped, decide, slot_last_nx;
  digit_t digit_nx;
  assign digit_nx = digit == LAST ? '0 : digit + 6'd1;
  assign slot_last_nx = state == SHORT_A ? digit_nx == HALF : digit_nx == LAST;
`ifdef EDSAC_SHORT_WORD_EN
  logic mid_decide;
  assign mid_decide = state == SHORT_A && digit == HALF;
  assign cand = mid_decide ? req & req_short : req;
  assign decide = word_end || mid_decide;
  assign next_state = !(|pick) ? IDLE : mid_decide ? SHORT_B : |(pick & req_short) ? SHORT_A : LONG;
`else
  assign cand = req;
  assign decide = word_end;
  assign next_state = |pick ? LONG : IDLE;
`endif
  rr_arbiter #(.N(NREQ), .W(PW)) u_rr (.req(cand), .ptr(ptr), .gnt(pick), .idx(idx));
  // A slot whose requester let go at any point is still run out but never reported done
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      word_start <= 1'b1;
      word_end <= 1'b0;
      gnt <= '0;
      busy <= 1'b0;
      xfer_done <= '0;
      ptr <= '0;
      dropped <= 1'b0;
      state <= IDLE;
    end else begin
      digit <= digit_nx;
      word_start <= digit_nx == '0;
      word_end <= digit_nx == LAST;
      xfer_done <= slot_last_nx && !dropped ? gnt & req : '0;
      dropped <= dropped | |(gnt & ~req);
      if (decide) begin
        gnt <= pick;
        busy <= |pick;
        dropped <= 1'b0;
        state <= next_state;
        if (|pick) ptr <= idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule
